zsdram_port_sched: RTL and testbench

Round-robin scheduler that shares the single 4-word-burst SDRAM engine among up to NPORT read/write requesters: display fetch, drawing, scrolling, and page or self-test writers. It sits between the page and draw modules and the SDRAM base module. It latches one request per grant, holds the engine request until the engine reports done, then returns a one-cycle done pulse and the read data. A per-port enable mask lets system mode (sync-lost, power-on self-test) select which requesters are eligible. A watchdog prevents a stuck engine from hanging the display.

---
 rtl/zsdram_pkg.sv | 22 ++
 rtl/zrr_pick.sv | 39 +++
 rtl/zsdram_port_sched.sv | 171 +++++++++++++++++
 tb/tb_zsdram_port_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zsdram_pkg.sv
// Shared definitions for the SDRAM port scheduler and its helpers.
// Contents: engine request/done encodings, scheduler state encoding,
// burst width and the default SDRAM address width.
package zsdram_pkg;

    // Four 16-bit words per engine burst.
    localparam int unsigned BURST_W = 64;

    // bank(2) + row(13) + col(9)
    localparam int unsigned AW_DEFAULT = 24;

    // Engine request / done bit positions: [1] write, [0] read.
    localparam logic [1:0] ENG_WR = 2'b10;
    localparam logic [1:0] ENG_RD = 2'b01;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDone  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/zrr_pick.sv
// Combinational round-robin picker.
// Searches req_i upward starting at ptr_i+1 (wrapping modulo N) and returns the
// first requester found.
//   req_i   : request vector
//   ptr_i   : index of the most recent winner
//   gnt_o   : one-hot grant, zero when nothing requests
//   idx_o   : index of the granted bit
//   valid_o : high when any request was found
module zrr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          req_i,
    input  logic [$clog2(N)-1:0]  ptr_i,
    output logic [N-1:0]          gnt_o,
    output logic [$clog2(N)-1:0]  idx_o,
    output logic                  valid_o
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        // i = N wraps back to ptr_i itself, so a lone requester re-wins.
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(ptr_i) + i) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/zsdram_port_sched.sv
// Round-robin scheduler sharing one 4-word-burst SDRAM engine among NPORT
// requesters (display fetch, drawing, scrolling, page/self-test writers).
// One request is latched per grant, the engine request is held until the
// matching done (or the watchdog expires), then a one-cycle done/err pulse is
// returned to the owning port.
//   clk, rst_n   : SDRAM-domain clock, async active-low reset
//   en           : low blocks new grants (in-flight burst is unaffected)
//   iPortMask    : per-port eligibility
//   iReq/iWrite  : per-port request level and direction (1 = write)
//   iAddr        : per-port address, port k at [k*AW +: AW]
//   iWrData      : per-port 64-bit write burst
//   oDone/oErr   : one-cycle completion / watchdog-abort pulse per port
//   oRdData      : read burst, valid while oDone is high
//   oGrant       : one-hot owner, zero when idle
//   oBusy        : high whenever not idle
//   oEngReq      : [1] write, [0] read request to the engine
//   oEngAddr     : latched address, oEngWrData: latched write burst
//   iEngDone     : [1] write done, [0] read done; iEngRdData: read burst
module zsdram_port_sched
    import zsdram_pkg::*;
#(
    parameter int unsigned NPORT = 4,
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned TMO   = 1023
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NPORT-1:0]           iPortMask,
    input  logic [NPORT-1:0]           iReq,
    input  logic [NPORT-1:0]           iWrite,
    input  logic [NPORT*AW-1:0]        iAddr,
    input  logic [NPORT*BURST_W-1:0]   iWrData,
    output logic [NPORT-1:0]           oDone,
    output logic [NPORT-1:0]           oErr,
    output logic [BURST_W-1:0]         oRdData,
    output logic [NPORT-1:0]           oGrant,
    output logic                       oBusy,
    output logic [1:0]                 oEngReq,
    output logic [AW-1:0]              oEngAddr,
    output logic [BURST_W-1:0]         oEngWrData,
    input  logic [1:0]                 iEngDone,
    input  logic [BURST_W-1:0]         iEngRdData
);

    localparam int unsigned PW = $clog2(NPORT);
    localparam int unsigned CW = $clog2(TMO + 1);

    sched_state_e         state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NPORT-1:0]     grant_q, grant_d;
    logic                 wr_q, wr_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [BURST_W-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           eng_req_q, eng_req_d;
    logic [NPORT-1:0]     done_q, done_d;
    logic [NPORT-1:0]     err_q, err_d;
    logic [BURST_W-1:0]   rd_q, rd_d;

    logic [NPORT-1:0]     eligible;
    logic [NPORT-1:0]     pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic                 pick_valid;
    logic                 eng_match;

    assign eligible = iReq & iPortMask;

    zrr_pick #(
        .N (NPORT)
    ) u_pick (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Only the done bit matching the latched direction counts.
    assign eng_match = wr_q ? iEngDone[1] : iEngDone[0];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        eng_req_d = eng_req_q;
        rd_d      = rd_q;
        done_d    = '0;
        err_d     = '0;

        unique case (state_q)
            StIdle: begin
                if (en && pick_valid) begin
                    grant_d   = pick_gnt;
                    ptr_d     = pick_idx;
                    wr_d      = iWrite[pick_idx];
                    addr_d    = iAddr[pick_idx*AW +: AW];
                    wdata_d   = iWrData[pick_idx*BURST_W +: BURST_W];
                    cnt_d     = '0;
                    eng_req_d = iWrite[pick_idx] ? ENG_WR : ENG_RD;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                cnt_d = cnt_q + CW'(1);
                // A done arriving in the timeout cycle still completes normally.
                if (eng_match) begin
                    eng_req_d = '0;
                    done_d    = grant_q;
                    if (!wr_q) begin
                        rd_d = iEngRdData;
                    end
                    state_d = StDone;
                end else if (cnt_d == CW'(TMO)) begin
                    eng_req_d = '0;
                    err_d     = grant_q;
                    state_d   = StDone;
                end
            end
            StDone: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= PW'(NPORT - 1);
            grant_q   <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            eng_req_q <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            eng_req_q <= eng_req_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
        end
    end

    assign oDone      = done_q;
    assign oErr       = err_q;
    assign oRdData    = rd_q;
    assign oGrant     = grant_q;
    assign oBusy      = (state_q != StIdle);
    assign oEngReq    = eng_req_q;
    assign oEngAddr   = addr_q;
    assign oEngWrData = wdata_q;

endmodule

// File: tb/tb_zsdram_port_sched.sv
// Scoreboard bench for zsdram_port_sched: stimulus pushes the expected
// completion of each transaction, a monitor pops and compares whenever the
// DUT pulses oDone or oErr. A small engine model and per-port requester model
// drive the DUT inputs.
module tb_zsdram_port_sched;
    import zsdram_pkg::*;

    localparam int unsigned NPORT = 4;
    localparam int unsigned AW    = 24;
    localparam int unsigned TMO   = 15;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [NPORT-1:0]     iPortMask;
    logic [NPORT-1:0]     iReq;
    logic [NPORT-1:0]     iWrite;
    logic [NPORT*AW-1:0]  iAddr;
    logic [NPORT*64-1:0]  iWrData;
    logic [NPORT-1:0]     oDone;
    logic [NPORT-1:0]     oErr;
    logic [63:0]          oRdData;
    logic [NPORT-1:0]     oGrant;
    logic                 oBusy;
    logic [1:0]           oEngReq;
    logic [AW-1:0]        oEngAddr;
    logic [63:0]          oEngWrData;
    logic [1:0]           iEngDone;
    logic [63:0]          iEngRdData;

    zsdram_port_sched #(
        .NPORT (NPORT),
        .AW    (AW),
        .TMO   (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .iPortMask  (iPortMask),
        .iReq       (iReq),
        .iWrite     (iWrite),
        .iAddr      (iAddr),
        .iWrData    (iWrData),
        .oDone      (oDone),
        .oErr       (oErr),
        .oRdData    (oRdData),
        .oGrant     (oGrant),
        .oBusy      (oBusy),
        .oEngReq    (oEngReq),
        .oEngAddr   (oEngAddr),
        .oEngWrData (oEngWrData),
        .iEngDone   (iEngDone),
        .iEngRdData (iEngRdData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [AW-1:0] port_addr  [NPORT];
    logic [63:0]   port_wdata [NPORT];

    for (genvar k = 0; k < NPORT; k++) begin : g_pack
        assign iAddr[k*AW +: AW]   = port_addr[k];
        assign iWrData[k*64 +: 64] = port_wdata[k];
    end

    typedef struct {
        int          port;
        bit          err;
        bit          wr;
        logic [23:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          want   [NPORT];
    int          served [NPORT];
    logic [63:0] last_rd;
    int          eng_lat;
    logic [3:0]  hang_mask;
    bit          spur;
    bit          fixed_en;
    logic [63:0] fixed_data;

    function automatic logic [63:0] eng_fn(input logic [23:0] a);
        return {a[15:0], ~a[15:0], 16'hC0DE, a[23:8]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp_v);
        end
    endtask

    task automatic push(input int p, input bit err, input int lat);
        exp_t e;
        e.port  = p;
        e.err   = err;
        e.wr    = iWrite[p];
        e.addr  = port_addr[p];
        e.wdata = port_wdata[p];
        e.lat   = lat;
        if (!err && !e.wr) begin
            last_rd = fixed_en ? fixed_data : eng_fn(port_addr[p]);
        end
        e.rdata = last_rd;
        exp_q.push_back(e);
    endtask

    // Engine model: answers the matching done bit after eng_lat request cycles.
    initial begin
        int eng_cnt;
        eng_cnt    = 0;
        iEngDone   = 2'b00;
        iEngRdData = '0;
        forever begin
            @(negedge clk);
            iEngDone = 2'b00;
            if (!rst_n || oEngReq == 2'b00) begin
                eng_cnt = 0;
            end else begin
                eng_cnt++;
                if ((oGrant & hang_mask) == 4'b0000) begin
                    if (eng_cnt == eng_lat) begin
                        iEngDone = oEngReq;
                    end else if (spur && eng_cnt == 2) begin
                        iEngDone = ~oEngReq;
                    end
                end
            end
            iEngRdData = fixed_en ? fixed_data : eng_fn(oEngAddr);
        end
    end

    // Requester model: a port holds iReq while it has unserved transactions.
    initial begin
        iReq = '0;
        for (int k = 0; k < NPORT; k++) served[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NPORT; k++) begin
                if (!rst_n) begin
                    served[k] = 0;
                end else if (oDone[k] || oErr[k]) begin
                    served[k]++;
                end
                iReq[k] = (want[k] > served[k]);
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int         run;
        logic [1:0] last_req;
        logic [3:0] onehot;
        exp_t       e;
        run      = 0;
        last_req = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else begin
                if (oEngReq != 2'b00) begin
                    run++;
                    last_req = oEngReq;
                end
                if ((oDone | oErr) != 4'b0000) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'(oDone | oErr), 64'(0));
                    end else begin
                        e      = exp_q.pop_front();
                        onehot = 4'b0001 << e.port;
                        chk($sformatf("done_p%0d", e.port), 64'(oDone),
                            64'(e.err ? 4'b0000 : onehot));
                        chk($sformatf("err_p%0d", e.port), 64'(oErr),
                            64'(e.err ? onehot : 4'b0000));
                        chk($sformatf("grant_p%0d", e.port), 64'(oGrant), 64'(onehot));
                        chk($sformatf("busy_p%0d", e.port), 64'(oBusy), 64'(1));
                        chk($sformatf("addr_p%0d", e.port), 64'(oEngAddr), 64'(e.addr));
                        if (e.wr) begin
                            chk($sformatf("wrdata_p%0d", e.port), oEngWrData, e.wdata);
                        end
                        chk($sformatf("rddata_p%0d", e.port), oRdData, e.rdata);
                        chk($sformatf("req_cycles_p%0d", e.port), 64'(run), 64'(e.lat));
                        chk($sformatf("req_dir_p%0d", e.port), 64'(last_req),
                            64'(e.wr ? ENG_WR : ENG_RD));
                    end
                    run = 0;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NPORT; k++) want[k] = 0;
        last_rd   = '0;
        hang_mask = 4'b0000;
        spur      = 1'b0;
        fixed_en  = 1'b0;
        eng_lat   = 6;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !oBusy && (iReq & iPortMask) == 4'b0000) ok = 1'b1;
        end
        if (!ok) begin
            chk({nm, "_pending"}, 64'(exp_q.size()), 64'(0));
            chk({nm, "_busy"}, 64'(oBusy), 64'(0));
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_issue(input int p, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (oGrant[p] && oEngReq != 2'b00) ok = 1'b1;
        end
        if (!ok) chk({nm, "_issue_seen"}, 64'(oGrant), 64'(4'b0001 << p));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        en         = 1'b1;
        iPortMask  = 4'b1111;
        iWrite     = 4'b0000;
        fixed_data = 64'h4444_3333_2222_1111;
        for (int k = 0; k < NPORT; k++) begin
            want[k]       = 0;
            port_addr[k]  = 24'hA0_0000 + 24'(k * 24'h1010);
            port_wdata[k] = {4{16'h5A00 + 16'(k)}} ^ 64'h0123_4567_89AB_CDEF;
        end

        // Reset values, during and after reset.
        do_reset();
        chk("rst_grant", 64'(oGrant), 64'(0));
        chk("rst_busy", 64'(oBusy), 64'(0));
        chk("rst_engreq", 64'(oEngReq), 64'(0));
        chk("rst_done", 64'(oDone), 64'(0));
        chk("rst_err", 64'(oErr), 64'(0));
        chk("rst_rddata", oRdData, 64'(0));
        chk("rst_addr", 64'(oEngAddr), 64'(0));
        chk("rst_wrdata", oEngWrData, 64'(0));

        // Single read on port 2 with a fixed engine burst.
        port_addr[2] = 24'h01_2340;
        fixed_en     = 1'b1;
        push(2, 1'b0, 6);
        want[2]++;
        drain("single_read");
        fixed_en = 1'b0;

        // Four ports saturated: 0,1,2,3,0,1,2,3.
        do_reset();
        iWrite = 4'b1010;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NPORT; p++) push(p, 1'b0, 6);
        for (int p = 0; p < NPORT; p++) want[p] = 2;
        drain("rr_all");

        // Mask 1010: only ports 1 and 3 alternate; 0 and 2 stay pending.
        do_reset();
        iPortMask = 4'b1010;
        iWrite    = 4'b0010;
        push(1, 1'b0, 6); push(3, 1'b0, 6); push(1, 1'b0, 6); push(3, 1'b0, 6);
        want[0] = 1; want[2] = 1; want[1] = 2; want[3] = 2;
        drain("mask_alt");

        // Masking port 1 while it is in flight must not abort its burst.
        do_reset();
        iPortMask = 4'b1010;
        iWrite    = 4'b0000;
        push(1, 1'b0, 6); push(3, 1'b0, 6);
        want[1] = 1; want[3] = 1;
        wait_issue(1, "mask_mid");
        iPortMask = 4'b1000;
        drain("mask_mid");

        // en low blocks grants; then watchdog abort on port 0, port 1 follows.
        iPortMask = 4'b1111;
        iWrite    = 4'b0000;
        en        = 1'b0;
        hang_mask = 4'b0001;
        push(0, 1'b1, int'(TMO));
        push(1, 1'b0, 6);
        want[0]++; want[1]++;
        repeat (5) @(negedge clk);
        chk("en_low_busy", 64'(oBusy), 64'(0));
        chk("en_low_grant", 64'(oGrant), 64'(0));
        en = 1'b1;
        drain("timeout");
        hang_mask = 4'b0000;

        // Write with a spurious read-done in flight.
        iWrite  = 4'b0100;
        spur    = 1'b1;
        eng_lat = 5;
        push(2, 1'b0, 5);
        want[2]++;
        drain("spurious");
        spur    = 1'b0;
        eng_lat = 6;

        // Reset mid-ISSUE, then port 0 beats port 3 on a tie.
        iWrite = 4'b0000;
        want[3]++;
        wait_issue(3, "rst_mid");
        rst_n = 1'b0;
        #1;
        chk("rst_mid_engreq", 64'(oEngReq), 64'(0));
        chk("rst_mid_grant", 64'(oGrant), 64'(0));
        chk("rst_mid_busy", 64'(oBusy), 64'(0));
        for (int k = 0; k < NPORT; k++) want[k] = 0;
        last_rd = '0;
        @(negedge clk);
        push(0, 1'b0, 6);
        push(3, 1'b0, 6);
        want[0] = 1; want[3] = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain("rst_tie");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
